// File: rtl/crypto_round_sequencer.sv
// Round sequencer for the combinational Cryptography_Module core: one block per NUM_ROUNDS+2 cycles.
// Optional perf counters (blocks_done, stall_cycles) when CRYPTO_SEQ_PERF_CNT_EN is defined.
module crypto_round_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_ROUNDS = 4,
  parameter int unsigned CNT_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_key,
  input  logic              in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [DATA_W-1:0] core_data_in,
  output logic [DATA_W-1:0] core_key,
  output logic [CNT_W-1:0]  core_cnt,
  output logic              core_sel,
  input  logic [DATA_W-1:0] core_result
`ifdef CRYPTO_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]       blocks_done,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // One extra bit so the index can reach NUM_ROUNDS (== 2**CNT_W) without wrapping.
  localparam int unsigned            IDX_W    = CNT_W + 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] data_reg, key_reg;
  logic              sel_reg;
  logic [IDX_W-1:0]  round_idx;
  logic              accept;

  assign accept       = in_valid && in_ready;
  assign busy         = (state != IDLE);
  assign core_data_in = data_reg;
  assign core_key     = key_reg;
  assign core_sel     = sel_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      key_reg   <= '0;
      sel_reg   <= 1'b0;
      round_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_reg  <= in_data;
            key_reg   <= in_key;
            sel_reg   <= in_sel;
            round_idx <= '0;
          end
        end
        ROUND: begin
          data_reg  <= core_result;
          round_idx <= round_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    core_cnt   = '0;
    case (state)
      IDLE: begin
        // Async reset holds state at IDLE, so rst must also mask the ready.
        in_ready = !rst;
        if (accept) state_next = ROUND;
      end
      ROUND: begin
        core_cnt = sel_reg ? CNT_W'(LAST_IDX - round_idx) : CNT_W'(round_idx);
        if (round_idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = data_reg;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CRYPTO_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blocks_done  <= '0;
      stall_cycles <= '0;
    end else begin
      if (out_valid && out_ready) blocks_done <= blocks_done + 16'd1;
      if ((state == DONE) && !out_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crypto_round_sequencer.sv
// Randomized self-checking bench for crypto_round_sequencer with a stub core (result = data + cnt + 1).
// Perf-counter checks are compiled in when CRYPTO_SEQ_PERF_CNT_EN is defined.
module tb_crypto_round_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sel;
  logic [DW-1:0] in_data, in_key;
  logic          out_valid, out_ready, busy;
  logic [DW-1:0] out_data;
  logic [DW-1:0] core_data_in, core_key, core_result;
  logic [CW-1:0] core_cnt;
  logic          core_sel;
`ifdef CRYPTO_SEQ_PERF_CNT_EN
  logic [15:0]   blocks_done, stall_cycles;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_blocks = 0;
  int unsigned exp_stall  = 0;

  always #5 clk = ~clk;

  assign core_result = core_data_in + {{(DW-CW){1'b0}}, core_cnt} + DW'(1);

  crypto_round_sequencer #(.DATA_W(DW), .NUM_ROUNDS(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .core_data_in(core_data_in), .core_key(core_key), .core_cnt(core_cnt), .core_sel(core_sel),
    .core_result(core_result)
`ifdef CRYPTO_SEQ_PERF_CNT_EN
    , .blocks_done(blocks_done), .stall_cycles(stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Round index order: ascending for encrypt, descending for decrypt.
  function automatic int unsigned ref_cnt(input logic sel, input int unsigned r);
    return sel ? (NR - 1 - r) : r;
  endfunction

  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] d, input logic sel);
    logic [DW-1:0] acc = d;
    for (int unsigned r = 0; r < NR; r++) acc = acc + DW'(ref_cnt(sel, r) + 1);
    return acc;
  endfunction

  task automatic run_block(input logic [DW-1:0] d, input logic [DW-1:0] k, input logic s,
                           input int unsigned stall, input int unsigned abort_at);
    logic [DW-1:0] exp_res;
    int unsigned   cnts[$];
    int unsigned   lat;
    bit            seen;
    exp_res  = ref_result(d, s);
    in_data  = d;
    in_key   = k;
    in_sel   = s;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    check("accept_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_key   = $urandom;
    in_sel   = 1'($urandom_range(0, 1));
    seen = 0;
    lat  = 0;
    for (int unsigned c = 1; c <= NR + 4 && !seen; c++) begin
      @(negedge clk);
      if (abort_at != 0 && c == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_cnt", core_cnt, 0);
        check("abort_rdy", in_ready, 0);
        exp_blocks = 0;
        exp_stall  = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (out_valid) begin
        seen = 1;
        lat  = c;
      end else begin
        cnts.push_back(int'(core_cnt));
        check("round_sel", core_sel, s);
        check("round_key", core_key, k);
        check("round_busy", busy, 1);
        check("round_rdy", in_ready, 0);
      end
    end
    if (!seen) begin
      check("out_timeout", 0, 1);
      return;
    end
    check("latency", lat, NR + 1);
    check("cnt_len", cnts.size(), NR);
    for (int unsigned r = 0; r < cnts.size() && r < NR; r++)
      check("cnt_seq", cnts[r], ref_cnt(s, r));
    for (int unsigned i = 0; i < stall; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_res);
      check("hold_rdy", in_ready, 0);
      check("hold_cnt", core_cnt, 0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = $urandom;
      if (i == stall - 1) out_ready = 1'b1;
      @(negedge clk);
    end
    check("out_valid", out_valid, 1);
    check("out_data", out_data, exp_res);
    check("done_rdy", in_ready, 0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_blocks++;
    exp_stall += stall;
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_rdy", in_ready, 1);
    check("post_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic back_to_back(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] k);
    int unsigned   acc_cyc[$];
    logic [DW-1:0] res[$];
    bit            acc;
    in_data   = a;
    in_key    = k;
    in_sel    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int unsigned c = 0; c < 40 && res.size() < 2; c++) begin
      @(negedge clk);
      if (out_valid) res.push_back(out_data);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc.push_back(c);
        if (acc_cyc.size() == 1) begin
          in_data = b;
          in_sel  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", acc_cyc.size(), 2);
    check("b2b_results", res.size(), 2);
    if (acc_cyc.size() == 2) check("b2b_gap", acc_cyc[1] - acc_cyc[0], NR + 2);
    if (res.size() >= 1) check("b2b_res0", res[0], ref_result(a, 1'b0));
    if (res.size() >= 2) check("b2b_res1", res[1], ref_result(b, 1'b1));
    exp_blocks += res.size();
  endtask

  task automatic check_perf();
`ifdef CRYPTO_SEQ_PERF_CNT_EN
    @(negedge clk);
    check("blocks_done", blocks_done, 16'(exp_blocks));
    check("stall_cycles", stall_cycles, 16'(exp_stall));
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] key;
    key       = 32'hC0FFEEEE;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    in_sel    = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_rdy", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", core_cnt, 0);
    check("rst_data", out_data, 0);
    check("rst_core_data", core_data_in, 0);
    check("rst_core_sel", core_sel, 0);
    check_perf();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_rdy", in_ready, 1);
    @(posedge clk); #1;

    check("ref_enc_const", ref_result(32'hDEADBEEF, 1'b0), 32'hDEADBEF9);
    check("ref_dec_const", ref_result(32'h1C025000, 1'b1), 32'h1C02500A);
    run_block(32'hDEADBEEF, key, 1'b0, 0, 0);
    run_block(32'h1C025000, key, 1'b1, 0, 0);
    run_block($urandom, $urandom, 1'b0, 7, 0);
    run_block(32'h12345678, key, 1'b0, 0, 3);
    check("abort_post_rdy", in_ready, 1);
    run_block(32'h00000000, key, 1'b0, 0, 0);
    back_to_back(32'hDEADBEEF, 32'h1C025000, key);
    check_perf();

    for (int unsigned n = 0; n < 10; n++)
      run_block($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    check_perf();

    @(negedge clk);
    rst = 1'b1;
    exp_blocks = 0;
    exp_stall  = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_block($urandom, key, 1'b0, 0, 0);
    run_block($urandom, key, 1'b1, 4, 0);
    run_block($urandom, key, 1'b0, 0, 0);
    check_perf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
